// File: rtl/imem_stream_loader.sv
// imem_stream_loader: receives a byte stream (4-byte little-endian word count N,
// then N little-endian 32-bit words) over a valid/ready link and writes the
// words to consecutive instruction RAM addresses starting at BASE_ADDR.
// The core is held in reset until the whole image has been written.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  input  logic        i_reload,
  output logic        o_imem_write_en,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_data,
  output logic        o_core_rst_n,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_FINAL = S_CSUM;
`else
  localparam logic [2:0] S_FINAL = S_DONE;
`endif

  logic [2:0]  state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] len_reg;
  logic [31:0] word_reg;
  logic [31:0] len_next;
  logic [31:0] word_next;
  logic        run;
  logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_reg;
`endif

  // Ready is gated by a flag set on the first clock after reset so it stays
  // low through reset and rises one edge after deassertion.
  always_comb begin
    o_byte_ready = 1'b0;
    if (run) begin
      case (state)
        S_LEN, S_DATA: o_byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM:        o_byte_ready = 1'b1;
`endif
        default:       o_byte_ready = 1'b0;
      endcase
    end
  end

  assign xfer      = i_byte_valid && o_byte_ready;
  assign len_next  = {i_byte_data, len_reg[31:8]};
  assign word_next = {i_byte_data, word_reg[31:8]};

  // Next-state decode for the load sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_LEN: begin
        if (xfer && byte_cnt == 2'd3) begin
          if (len_next == '0)
            state_next = S_FINAL;
          else if (len_next > 32'(MAX_WORDS))
            state_next = S_ERR;
          else
            state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt == 2'd3)
          state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = (word_cnt + 32'd1 == len_reg) ? S_FINAL : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer)
          state_next = (i_byte_data == xor_reg) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (i_reload)
          state_next = S_LEN;
      end
      default: state_next = S_LEN;
    endcase
  end

  // State, datapath and registered status outputs; status flags are decoded
  // from state_next so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_LEN;
      run             <= 1'b0;
      byte_cnt        <= '0;
      word_cnt        <= '0;
      len_reg         <= '0;
      word_reg        <= '0;
      o_imem_write_en <= 1'b0;
      o_imem_addr     <= BASE_ADDR;
      o_imem_data     <= '0;
      o_core_rst_n    <= 1'b0;
      o_done          <= 1'b0;
      o_error         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_reg         <= '0;
`endif
    end else begin
      state           <= state_next;
      run             <= 1'b1;
      o_imem_write_en <= (state_next == S_WRITE);
      o_done          <= (state_next == S_DONE);
      o_core_rst_n    <= (state_next == S_DONE);
      o_error         <= (state_next == S_ERR);

      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_LEN)
          len_reg <= len_next;
        if (state == S_DATA)
          word_reg <= word_next;
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == S_LEN)
        xor_reg <= '0;
      else if (xfer && state == S_DATA)
        xor_reg <= xor_reg ^ i_byte_data;
`endif

      if (state_next == S_WRITE) begin
        o_imem_addr <= BASE_ADDR + {word_cnt[29:0], 2'b00};
        o_imem_data <= word_next;
      end

      if (state == S_WRITE)
        word_cnt <= word_cnt + 32'd1;

      if ((state == S_DONE || state == S_ERR) && state_next == S_LEN) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        len_reg  <= '0;
        word_reg <= '0;
      end
    end
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Write-side master for the instruction RAM's external write port (write enable, address, data).
- Receives a byte stream from a host link through a valid/ready handshake.
- Packs the bytes little-endian into 32-bit instructions and writes them to consecutive word addresses.
- Holds the core in reset until the image is fully loaded, then releases it so the PC starts fetching from the loaded image.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first instruction word written.
- MAX_WORDS, 256, largest word count accepted. This is the instruction RAM depth in words.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_byte_valid  input  1  host byte is present on i_byte_data.
- i_byte_data  input  8  host byte.
- o_byte_ready  output  1  loader accepts a byte this cycle. A transfer happens when i_byte_valid && o_byte_ready.
- i_reload  input  1  single-cycle pulse; restarts loading from DONE or ERR.
- o_imem_write_en  output  1  instruction RAM write strobe, one cycle per word.
- o_imem_addr  output  32  instruction RAM write byte address.
- o_imem_data  output  32  instruction word.
- o_core_rst_n  output  1  active-low reset driven to the core. Low while loading.
- o_done  output  1  image loaded and core released.
- o_error  output  1  load aborted.

Behaviour:
- Reset is asynchronous and active-low on rst_n. While rst_n is low:
  - state = LEN; byte, word and length counters = 0; shift register = 0.
  - o_imem_write_en = 0, o_imem_addr = BASE_ADDR, o_imem_data = 0.
  - o_core_rst_n = 0, o_done = 0, o_error = 0.
  - o_byte_ready = 0 during reset; it rises to 1 on the first clock after deassertion.
- Stream format, all fields little-endian:
  - 4 header bytes giving word count N (32 bits).
  - N x 4 data bytes; the first byte of each word maps to [7:0].
- State LEN:
  - o_byte_ready = 1.
  - Each transfer shifts the byte into the length register.
  - After the 4th byte:
    - N == 0 -> DONE (or the checksum stage if CHECKSUM_EN).
    - N > MAX_WORDS -> ERR.
    - Otherwise -> DATA.
- State DATA:
  - o_byte_ready = 1.
  - Bytes are assembled into the word register.
  - The transfer of the 4th byte moves the FSM to WRITE.
- State WRITE (one cycle):
  - o_byte_ready = 0.
  - o_imem_write_en = 1; o_imem_addr = BASE_ADDR + 4*k, where k is the 0-based word index; o_imem_data = the assembled word.
  - Then k increments. If k == N -> DONE (or the checksum stage); otherwise -> DATA.
- Timing:
  - The write strobe occurs exactly 1 cycle after the 4th byte's transfer.
  - Peak throughput is one byte per cycle, except the one stall cycle per word.
- State DONE:
  - o_byte_ready = 0, o_done = 1.
  - o_core_rst_n = 1, registered, so it rises on the clock edge entering DONE.
- State ERR:
  - o_byte_ready = 0, o_error = 1, o_core_rst_n stays 0.
  - Any further bytes are not accepted; the host sees ready held low.
- i_reload:
  - In DONE or ERR: return to LEN and clear counters; o_done, o_error and o_core_rst_n drop to 0 on the same edge.
  - In LEN, DATA or WRITE: ignored.
- o_imem_write_en is never high outside WRITE.
- o_imem_addr and o_imem_data hold their last values between writes.
- i_byte_valid with o_byte_ready low is ignored; no byte is lost because the host must hold valid.
- Address arithmetic is 32-bit with wrap-around; no range check beyond MAX_WORDS.
- rst_n asserted mid-load aborts immediately. A partial image may remain in RAM; the core stays in reset and loading restarts from LEN.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last word (or after the header when N == 0), state CSUM accepts exactly one byte with o_byte_ready = 1.
  - That byte must equal the XOR of all data bytes (0x00 when N == 0).
  - Match -> DONE. Mismatch -> ERR; RAM contents are already written but the core stays in reset.
  - A running XOR register is cleared in LEN.
- When undefined: no CSUM state and no XOR register; the FSM moves directly to DONE after the last WRITE.

Test Plan:
- Reset then stream 02 00 00 00, 13 00 00 00, 93 00 10 00 (valid held high) -> two write strobes: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; o_done = 1 and o_core_rst_n = 1 one cycle after the 2nd strobe.
- Header 00 00 00 00 -> no write strobe; DONE reached the cycle after the 4th header byte (checksum build: after checksum byte 00).
- Header 01 01 00 00 (N = 257 > 256) -> o_error = 1, o_byte_ready = 0, o_core_rst_n = 0; then i_reload pulse -> LEN, ready = 1, error = 0.
- Valid toggling every other cycle during the data phase -> word assembled correctly; each strobe occurs 1 cycle after the 4th accepted byte; ready is low in each WRITE cycle.
- rst_n pulsed low after 6 bytes -> outputs at reset values; a fresh full stream then loads correctly from BASE_ADDR.
- IMEM_LOADER_CHECKSUM_EN: N = 1, word 13 00 00 00, checksum 0x13 -> DONE; same with checksum 0x12 -> ERR, core held in reset.
